// File: rtl/madam_span_pkg.sv
// Shared types and the clip-window test for the madam span writer.
// Coordinates are two's complement on input; the window is [0, clip] unsigned.
package madam_span_pkg;

  localparam int SPAN_COORD_W = 16;
  localparam int SPAN_LEN_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    DONE
  } span_state_t;

  typedef struct packed {
    logic [SPAN_COORD_W-1:0] x;
    logic [SPAN_COORD_W-1:0] y;
    logic [SPAN_LEN_W-1:0]   len;
    logic                    dir;
    logic                    skip_zero;
  } span_cmd_t;

  // A negative coordinate has its sign bit set, so it fails before the unsigned compare matters.
  function automatic logic in_window(
    input logic [SPAN_COORD_W-1:0] x,
    input logic [SPAN_COORD_W-1:0] y,
    input logic [SPAN_COORD_W-1:0] clip_x,
    input logic [SPAN_COORD_W-1:0] clip_y
  );
    return !x[SPAN_COORD_W-1] && (x <= clip_x) &&
           !y[SPAN_COORD_W-1] && (y <= clip_y);
  endfunction

endpackage

// File: rtl/madam_span_clip.sv
// Per-pixel drop decision (clip window + transparent zero) and the cur_x stepper.
// cur_x wraps silently; wrapped values land outside the window and get dropped.
module madam_span_clip
  import madam_span_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16,
  parameter int COORD_WIDTH = SPAN_COORD_W
) (
  input  logic                   i_aclk,
  input  logic                   i_areset,
  input  logic                   i_load,
  input  logic [COORD_WIDTH-1:0] i_load_x,
  input  logic                   i_step,
  input  logic                   i_dir,
  input  logic [COORD_WIDTH-1:0] i_y,
  input  logic [COORD_WIDTH-1:0] i_clip_x,
  input  logic [COORD_WIDTH-1:0] i_clip_y,
  input  logic                   i_skip_zero,
  input  logic [PIXEL_WIDTH-1:0] i_pix,
  output logic [COORD_WIDTH-1:0] o_cur_x,
  output logic                   o_drop
);

  logic [COORD_WIDTH-1:0] r_cur_x;
  logic                   w_transparent;

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_cur_x <= '0;
    end else if (i_load) begin
      r_cur_x <= i_load_x;
    end else if (i_step) begin
      r_cur_x <= i_dir ? (r_cur_x - COORD_WIDTH'(1)) : (r_cur_x + COORD_WIDTH'(1));
    end
  end

  assign w_transparent = i_skip_zero && (i_pix == '0);
  assign o_drop        = !in_window(r_cur_x, i_y, i_clip_x, i_clip_y) || w_transparent;
  assign o_cur_x       = r_cur_x;

endmodule

// File: rtl/madam_span_writer.sv
// Turns span commands plus a pixel stream into single-pixel frame_buffer writes,
// skipping clipped and transparent pixels so frame_buffer only sees visible ones.
module madam_span_writer
  import madam_span_pkg::*;
#(
  parameter int PIXEL_WIDTH = 16,
  parameter int COORD_WIDTH = SPAN_COORD_W,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [COORD_WIDTH-1:0] cmd_x,
  input  logic [COORD_WIDTH-1:0] cmd_y,
  input  logic [15:0]            cmd_len,
  input  logic                   cmd_dir,
  input  logic                   cmd_skip_zero,
  input  logic [COORD_WIDTH-1:0] clip_x,
  input  logic [COORD_WIDTH-1:0] clip_y,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  output logic [PIXEL_WIDTH-1:0] fb_pixel,
  output logic [COORD_WIDTH-1:0] fb_x,
  output logic [COORD_WIDTH-1:0] fb_y,
  output logic                   fb_req,
  input  logic                   fb_resp,
  output logic                   span_done,
  output logic [CNT_WIDTH-1:0]   pix_written
);

  span_state_t            r_state;
  span_state_t            w_next;
  span_cmd_t              w_cmd;

  logic [COORD_WIDTH-1:0] r_y;
  logic [COORD_WIDTH-1:0] r_clip_x;
  logic [COORD_WIDTH-1:0] r_clip_y;
  logic [SPAN_LEN_W-1:0]  r_remaining;
  logic                   r_dir;
  logic                   r_skip_zero;
  logic [PIXEL_WIDTH-1:0] r_fb_pixel;
  logic [COORD_WIDTH-1:0] r_fb_x;
  logic [COORD_WIDTH-1:0] r_fb_y;
  logic                   r_fb_req;
  logic                   r_span_done;
  logic [CNT_WIDTH-1:0]   r_pix_written;

  logic                   w_load;
  logic                   w_step;
  logic                   w_issue;
  logic                   w_resp;
  logic                   w_last;
  logic                   w_drop;
  logic [COORD_WIDTH-1:0] w_cur_x;

  assign w_cmd = '{x: cmd_x, y: cmd_y, len: cmd_len, dir: cmd_dir, skip_zero: cmd_skip_zero};
  assign w_last = (r_remaining == SPAN_LEN_W'(1));

  madam_span_clip #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .COORD_WIDTH (COORD_WIDTH)
  ) u_clip (
    .i_aclk      (aclk),
    .i_areset    (areset),
    .i_load      (w_load),
    .i_load_x    (w_cmd.x),
    .i_step      (w_step),
    .i_dir       (r_dir),
    .i_y         (r_y),
    .i_clip_x    (r_clip_x),
    .i_clip_y    (r_clip_y),
    .i_skip_zero (r_skip_zero),
    .i_pix       (pix_data),
    .o_cur_x     (w_cur_x),
    .o_drop      (w_drop)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    pix_ready = 1'b0;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_issue   = 1'b0;
    w_resp    = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_load = 1'b1;
          w_next = (w_cmd.len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (w_drop) begin
            w_step = 1'b1;
            w_next = w_last ? DONE : FETCH;
          end else begin
            w_issue = 1'b1;
            w_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (fb_resp) begin
          w_step = 1'b1;
          w_resp = 1'b1;
          w_next = w_last ? DONE : FETCH;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The request always falls for at least one cycle because ISSUE only ever returns to FETCH or DONE.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_y           <= '0;
      r_clip_x      <= '0;
      r_clip_y      <= '0;
      r_remaining   <= '0;
      r_dir         <= 1'b0;
      r_skip_zero   <= 1'b0;
      r_fb_pixel    <= '0;
      r_fb_x        <= '0;
      r_fb_y        <= '0;
      r_fb_req      <= 1'b0;
      r_span_done   <= 1'b0;
      r_pix_written <= '0;
    end else begin
      r_span_done <= (r_state == DONE);
      if (w_load) begin
        r_y         <= w_cmd.y;
        r_remaining <= w_cmd.len;
        r_dir       <= w_cmd.dir;
        r_skip_zero <= w_cmd.skip_zero;
        r_clip_x    <= clip_x;
        r_clip_y    <= clip_y;
      end else if (w_step) begin
        r_remaining <= r_remaining - SPAN_LEN_W'(1);
      end
      if (w_issue) begin
        r_fb_req   <= 1'b1;
        r_fb_pixel <= pix_data;
        r_fb_x     <= w_cur_x;
        r_fb_y     <= r_y;
      end else if (w_resp) begin
        r_fb_req   <= 1'b0;
        r_fb_pixel <= '0;
        r_fb_x     <= '0;
        r_fb_y     <= '0;
      end
      if (w_resp) begin
        r_pix_written <= r_pix_written + CNT_WIDTH'(1);
      end
    end
  end

  assign fb_pixel    = r_fb_pixel;
  assign fb_x        = r_fb_x;
  assign fb_y        = r_fb_y;
  assign fb_req      = r_fb_req;
  assign span_done   = r_span_done;
  assign pix_written = r_pix_written;

endmodule

// File: tb/tb_madam_span_writer.sv
// Bench for madam_span_writer: span vector table, frame_buffer responder model
// and a write scoreboard, plus hand sequences for zero-length, stall and reset cases.
module tb_madam_span_writer;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] len;
    logic        dir;
    logic        skip;
    logic [15:0] clipX;
    logic [15:0] clipY;
    logic [15:0] pix [8];
    int          expWrites;
  } spanVec_t;

  typedef struct packed {
    logic [15:0] pixel;
    logic [15:0] x;
    logic [15:0] y;
  } fbWrite_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_x;
  logic [15:0] cmd_y;
  logic [15:0] cmd_len;
  logic        cmd_dir;
  logic        cmd_skip_zero;
  logic [15:0] clip_x;
  logic [15:0] clip_y;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic [15:0] fb_pixel;
  logic [15:0] fb_x;
  logic [15:0] fb_y;
  logic        fb_req;
  logic        fb_resp;
  logic        span_done;
  logic [31:0] pix_written;

  int       tests = 0;
  int       failed = 0;
  int       cyc = 0;
  int       respDelay = 3;
  bit       strayMode = 1'b0;
  int       reqAge = 0;
  bit       prevReq = 1'b0;
  int       reqRises = 0;
  int       lastFallCyc = 0;
  int       acceptCyc = 0;
  bit       pixReadySeen = 1'b0;
  int       expWritten = 0;
  logic [47:0] heldFb;
  fbWrite_t sbQ [$];
  spanVec_t vecs [10];

  madam_span_writer #(
    .PIXEL_WIDTH (16),
    .COORD_WIDTH (16),
    .CNT_WIDTH   (32)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_x         (cmd_x),
    .cmd_y         (cmd_y),
    .cmd_len       (cmd_len),
    .cmd_dir       (cmd_dir),
    .cmd_skip_zero (cmd_skip_zero),
    .clip_x        (clip_x),
    .clip_y        (clip_y),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .fb_pixel      (fb_pixel),
    .fb_x          (fb_x),
    .fb_y          (fb_y),
    .fb_req        (fb_req),
    .fb_resp       (fb_resp),
    .span_done     (span_done),
    .pix_written   (pix_written)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    failed++;
    $display("[TB] FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // Monitor plus frame_buffer model: compares each new request against the scoreboard
  // and answers it respDelay cycles later; optional stray resp pulses while idle.
  always @(negedge aclk) begin
    if (areset) begin
      prevReq = 1'b0;
      reqAge  = 0;
      fb_resp = 1'b0;
    end else begin
      if (fb_req && !prevReq) begin
        fbWrite_t e;
        reqRises++;
        if (sbQ.size() == 0) begin
          tests++;
          failed++;
          $display("[TB] FAIL unexpected write: got pixel 0x%0h at (0x%0h,0x%0h), required none",
                   fb_pixel, fb_x, fb_y);
        end else begin
          e = sbQ.pop_front();
          checkOutput("fb_pixel", 64'(fb_pixel), 64'(e.pixel));
          checkOutput("fb_x", 64'(fb_x), 64'(e.x));
          checkOutput("fb_y", 64'(fb_y), 64'(e.y));
        end
        heldFb = {fb_pixel, fb_x, fb_y};
      end else if (fb_req) begin
        checkOutput("fb hold while req", 64'({fb_pixel, fb_x, fb_y}), 64'(heldFb));
      end else begin
        checkOutput("fb outputs zero while idle", 64'({fb_pixel, fb_x, fb_y}), 64'd0);
        if (prevReq) lastFallCyc = cyc;
      end
      prevReq = fb_req;
      if (fb_req) begin
        reqAge++;
        fb_resp = (reqAge == respDelay);
      end else begin
        reqAge  = 0;
        fb_resp = strayMode ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  function automatic spanVec_t mkVec(input logic [15:0] x, input logic [15:0] y, input logic [15:0] len,
                                     input logic dir, input logic skip,
                                     input logic [15:0] cx, input logic [15:0] cy,
                                     input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                                     input logic [15:0] p3, input logic [15:0] p4, input int expW);
    spanVec_t v;
    v.x = x; v.y = y; v.len = len; v.dir = dir; v.skip = skip;
    v.clipX = cx; v.clipY = cy;
    v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2; v.pix[3] = p3; v.pix[4] = p4;
    v.pix[5] = 16'h0; v.pix[6] = 16'h0; v.pix[7] = 16'h0;
    v.expWrites = expW;
    return v;
  endfunction

  task automatic modelSpan(input spanVec_t v);
    logic [15:0] cx;
    cx = v.x;
    for (int i = 0; i < int'(v.len); i++) begin
      logic drop;
      drop = cx[15] || (cx > v.clipX) || v.y[15] || (v.y > v.clipY) || (v.skip && v.pix[i] == 16'h0);
      if (!drop) sbQ.push_back('{pixel: v.pix[i], x: cx, y: v.y});
      cx = v.dir ? (cx - 16'd1) : (cx + 16'd1);
    end
  endtask

  task automatic applyStimulus(input spanVec_t v, input int validPct);
    int budget;
    int idx;
    modelSpan(v);
    pixReadySeen = 1'b0;
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_x = v.x; cmd_y = v.y; cmd_len = v.len;
    cmd_dir = v.dir; cmd_skip_zero = v.skip; clip_x = v.clipX; clip_y = v.clipY;
    budget = 0;
    while (!cmd_ready && budget < 100) begin
      @(negedge aclk);
      budget++;
    end
    if (!cmd_ready) timeoutFail("cmd accept");
    acceptCyc = cyc;
    @(negedge aclk);
    cmd_valid = 1'b0;
    cmd_x = 16'($urandom); cmd_y = 16'($urandom); cmd_len = 16'($urandom);
    clip_x = 16'h0; clip_y = 16'h0;
    idx = 0;
    budget = 0;
    while (idx < int'(v.len) && budget < 2000) begin
      pix_valid = ($urandom_range(0, 99) < validPct);
      pix_data  = pix_valid ? v.pix[idx] : 16'($urandom);
      if (pix_ready) pixReadySeen = 1'b1;
      if (pix_valid && pix_ready) idx++;
      @(negedge aclk);
      budget++;
    end
    pix_valid = 1'b0;
    if (idx < int'(v.len)) timeoutFail("pixel consume");
  endtask

  task automatic finishSpan(input int expW, output int doneCyc);
    int budget;
    budget = 0;
    doneCyc = -1;
    while (!span_done && budget < 500) begin
      if (pix_ready) pixReadySeen = 1'b1;
      @(negedge aclk);
      budget++;
    end
    if (!span_done) begin
      timeoutFail("span_done");
    end else begin
      doneCyc = cyc;
      @(negedge aclk);
      checkOutput("span_done one cycle", 64'(span_done), 64'd0);
    end
    checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);
    sbQ.delete();
    expWritten += expW;
    checkOutput("pix_written", 64'(pix_written), 64'(expWritten));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    spanVec_t sv;
    int doneCyc;
    int reqBefore;
    int nz;
    int budget;

    vecs[0] = mkVec(16'h00EC, 16'h0082, 16'd1, 1'b0, 1'b0, 16'h013F, 16'h00EF, 16'hA108, 16'h0, 16'h0, 16'h0, 16'h0, 1);
    vecs[1] = mkVec(16'hFFFE, 16'h0005, 16'd5, 1'b0, 1'b0, 16'h0001, 16'h00EF, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 2);
    vecs[2] = mkVec(16'h000A, 16'h0007, 16'd4, 1'b0, 1'b1, 16'h013F, 16'h00EF, 16'h0, 16'h1234, 16'h0, 16'hFFFF, 16'h0, 2);
    vecs[3] = mkVec(16'h000A, 16'h0007, 16'd4, 1'b0, 1'b0, 16'h013F, 16'h00EF, 16'h0, 16'h1234, 16'h0, 16'hFFFF, 16'h0, 4);
    vecs[4] = mkVec(16'h0003, 16'h0010, 16'd3, 1'b1, 1'b0, 16'h013F, 16'h00EF, 16'h11, 16'h22, 16'h33, 16'h0, 16'h0, 3);
    vecs[5] = mkVec(16'h013E, 16'h00EF, 16'd3, 1'b0, 1'b0, 16'h013F, 16'h00EF, 16'h7, 16'h8, 16'h9, 16'h0, 16'h0, 2);
    vecs[6] = mkVec(16'h0005, 16'hFFFF, 16'd2, 1'b0, 1'b0, 16'h013F, 16'h00EF, 16'h7, 16'h8, 16'h0, 16'h0, 16'h0, 0);
    vecs[7] = mkVec(16'h0005, 16'h00F0, 16'd1, 1'b0, 1'b0, 16'h013F, 16'h00EF, 16'h7, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    vecs[8] = mkVec(16'h7FFF, 16'h0000, 16'd2, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0A0A, 16'h0B0B, 16'h0, 16'h0, 16'h0, 1);
    vecs[9] = mkVec(16'h0000, 16'h0001, 16'd2, 1'b1, 1'b0, 16'h013F, 16'h00EF, 16'h0C0C, 16'h0D0D, 16'h0, 16'h0, 16'h0, 1);

    areset = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_len = '0; cmd_dir = 1'b0;
    cmd_skip_zero = 1'b0; clip_x = '0; clip_y = '0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge aclk);
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("reset pix_ready", 64'(pix_ready), 64'd0);
    checkOutput("reset fb_req", 64'(fb_req), 64'd0);
    checkOutput("reset fb outputs", 64'({fb_pixel, fb_x, fb_y}), 64'd0);
    checkOutput("reset span_done", 64'(span_done), 64'd0);
    checkOutput("reset pix_written", 64'(pix_written), 64'd0);
    areset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      strayMode = (i >= 2);
      applyStimulus(vecs[i], 100);
      finishSpan(vecs[i].expWrites, doneCyc);
      if (i == 0) checkOutput("single: span_done after fb_req fall", 64'(doneCyc - lastFallCyc), 64'd1);
    end
    strayMode = 1'b0;

    // Zero-length span straight after the reverse span.
    applyStimulus(vecs[4], 100);
    finishSpan(3, doneCyc);
    reqBefore = reqRises;
    sv = mkVec(16'h0005, 16'h0005, 16'd0, 1'b0, 1'b0, 16'h013F, 16'h00EF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    applyStimulus(sv, 100);
    finishSpan(0, doneCyc);
    checkOutput("zero len: span_done latency", 64'(doneCyc - acceptCyc), 64'd2);
    checkOutput("zero len: pix_ready seen", 64'(pixReadySeen), 64'd0);
    checkOutput("zero len: fb_req count", 64'(reqRises), 64'(reqBefore));

    // Stall: random pixel valid and slow frame_buffer.
    respDelay = 10;
    sv = mkVec(16'd100, 16'd50, 16'd8, 1'b0, 1'b1, 16'h013F, 16'h00EF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0);
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      sv.pix[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      if (sv.pix[i] != 16'h0) nz++;
    end
    applyStimulus(sv, 50);
    finishSpan(nz, doneCyc);

    // Reset while a request is outstanding.
    respDelay = 20;
    sbQ.push_back('{pixel: 16'h5555, x: 16'd20, y: 16'd20});
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_x = 16'd20; cmd_y = 16'd20; cmd_len = 16'd3; cmd_dir = 1'b0;
    cmd_skip_zero = 1'b0; clip_x = 16'h013F; clip_y = 16'h00EF;
    @(negedge aclk);
    cmd_valid = 1'b0; pix_valid = 1'b1; pix_data = 16'h5555;
    @(negedge aclk);
    pix_valid = 1'b0;
    budget = 0;
    while (!fb_req && budget < 20) begin
      @(negedge aclk);
      budget++;
    end
    if (!fb_req) timeoutFail("reset test fb_req");
    #2 areset = 1'b1;
    #1;
    checkOutput("mid reset fb_req", 64'(fb_req), 64'd0);
    checkOutput("mid reset fb outputs", 64'({fb_pixel, fb_x, fb_y}), 64'd0);
    checkOutput("mid reset pix_written", 64'(pix_written), 64'd0);
    checkOutput("mid reset span_done", 64'(span_done), 64'd0);
    checkOutput("mid reset cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("mid reset pix_ready", 64'(pix_ready), 64'd0);
    sbQ.delete();
    expWritten = 0;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      checkOutput("no span_done after reset", 64'(span_done), 64'd0);
    end
    respDelay = 3;
    applyStimulus(vecs[4], 100);
    finishSpan(3, doneCyc);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
